// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM/I2S deserializer.
package pcm_pkg;

    localparam int PCM_WIDTH_DEF = 18;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2
    } pcm_state_e;

endpackage

// File: rtl/pcm_ws_sync.sv
// Word-select history, edge strobe and PRIME/SYNC/RUN framing state.
module pcm_ws_sync
    import pcm_pkg::*;
(
    input  logic       bclk,
    input  logic       reset,
    input  logic       en,
    input  logic       ws,
    output logic       ws_q,
    output logic       ws_edge,
    output pcm_state_e state
);

    pcm_state_e state_nxt;

    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            state <= PRIME;
            ws_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            ws_q  <= ws;
        end
    end

    // PRIME only refreshes ws_q, so a stale ws_q can never fake an edge.
    assign ws_edge = (state != PRIME) && (ws != ws_q);

    always_comb begin
        state_nxt = state;
        unique case (state)
            PRIME:   if (en) state_nxt = SYNC;
            SYNC:    if (!en) state_nxt = PRIME;
                     else if (ws_edge) state_nxt = RUN;
            RUN:     if (!en) state_nxt = PRIME;
            default: state_nxt = PRIME;
        endcase
    end

endmodule

// File: rtl/pcm_deser.sv
// Serial PCM/I2S receiver: collects bits per ws half-frame and emits aligned words.
module pcm_deser
    import pcm_pkg::*;
#(
    parameter int WIDTH     = PCM_WIDTH_DEF,
    parameter int MSB_FIRST = 1,
    parameter int DELAY     = 1
) (
    input  logic             bclk,
    input  logic             reset,
    input  logic             en,
    input  logic             ws,
    input  logic             d_in,
    output logic [WIDTH-1:0] data,
    output logic             ch,
    output logic             data_valid,
    output logic             short_err,
    output logic             locked
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic             ws_q;
    logic             ws_edge;
    pcm_state_e       state;
    logic [WIDTH-1:0] sr_p0, sr_app, sr_cap, sr_new;
    logic [CW-1:0]    cnt_p0, cnt_app, cnt_cap, cnt_new;

    // Bits arriving once the word is full are dropped silently.
    function automatic logic [WIDTH-1:0] put_bit(input logic [WIDTH-1:0] sr,
                                                 input logic [CW-1:0] cnt,
                                                 input logic b);
        if (cnt == FULL) return sr;
        if (MSB_FIRST != 0) return {sr[WIDTH-2:0], b};
        return sr | ({{(WIDTH-1){1'b0}}, b} << cnt);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        return (cnt == FULL) ? cnt : cnt + CW'(1);
    endfunction

    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] sr,
                                               input logic [CW-1:0] cnt);
        if (MSB_FIRST != 0) return sr << (FULL - cnt);
        return sr;
    endfunction

    pcm_ws_sync u_ws_sync (
        .bclk   (bclk),
        .reset  (reset),
        .en     (en),
        .ws     (ws),
        .ws_q   (ws_q),
        .ws_edge(ws_edge),
        .state  (state)
    );

    // The edge-cycle bit either finishes the old word (I2S) or opens the new one.
    always_comb begin
        sr_app  = put_bit(sr_p0, cnt_p0, d_in);
        cnt_app = sat_inc(cnt_p0);
        if (DELAY != 0) begin
            sr_cap  = sr_app;
            cnt_cap = cnt_app;
            sr_new  = '0;
            cnt_new = '0;
        end else begin
            sr_cap  = sr_p0;
            cnt_cap = cnt_p0;
            sr_new  = put_bit('0, '0, d_in);
            cnt_new = CW'(1);
        end
    end

    always_ff @(posedge bclk or negedge reset) begin
        if (!reset) begin
            sr_p0      <= '0;
            cnt_p0     <= '0;
            data       <= '0;
            ch         <= 1'b0;
            data_valid <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            short_err  <= 1'b0;
            // A word closed by an edge is delivered even if en drops in that cycle.
            if (state == RUN && ws_edge) begin
                data       <= align(sr_cap, cnt_cap);
                ch         <= ws_q;
                data_valid <= 1'b1;
                short_err  <= (cnt_cap != FULL);
                sr_p0      <= sr_new;
                cnt_p0     <= cnt_new;
            end else if (en && state == SYNC && ws_edge) begin
                sr_p0  <= sr_new;
                cnt_p0 <= cnt_new;
            end else if (en && state == RUN) begin
                sr_p0  <= sr_app;
                cnt_p0 <= cnt_app;
            end else begin
                sr_p0  <= '0;
                cnt_p0 <= '0;
            end
        end
    end

    assign locked = (state == RUN);

endmodule

// File: tb/tb_pcm_deser.sv
// Bench for pcm_deser: I2S/MSB-first and left-justified/LSB-first instances on one stream.
module tb_pcm_deser;

    localparam int W = 18;

    logic         bclk = 1'b0;
    logic         reset, en, ws, d_in;
    logic [W-1:0] data0, data1;
    logic         ch0, ch1, dv0, dv1, se0, se1, lk0, lk1;

    always #5 bclk = ~bclk;

    pcm_deser #(.WIDTH(W), .MSB_FIRST(1), .DELAY(1)) u0 (
        .bclk(bclk), .reset(reset), .en(en), .ws(ws), .d_in(d_in),
        .data(data0), .ch(ch0), .data_valid(dv0), .short_err(se0), .locked(lk0)
    );

    pcm_deser #(.WIDTH(W), .MSB_FIRST(0), .DELAY(0)) u1 (
        .bclk(bclk), .reset(reset), .en(en), .ws(ws), .d_in(d_in),
        .data(data1), .ch(ch1), .data_valid(dv1), .short_err(se1), .locked(lk1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: per-config framing mode (0 prime, 1 sync, 2 run) and the bit list of the open word.
    int          m_mode [2];
    bit          m_pws  [2];
    logic [31:0] m_data [2];
    bit          m_ch   [2];
    bit          m_valid[2];
    bit          m_short[2];
    bit          m_bits [2][32];
    int          m_n    [2];

    string fname[5] = '{"data", "ch", "data_valid", "short_err", "locked"};

    logic [31:0] first_d0, first_d1;
    bit          first_v0, first_v1, first_s0, first_s1, first_c0, first_c1;
    bit          pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_out(input int c, input int f);
        case (f)
            0:       return (c == 0) ? 32'(data0) : 32'(data1);
            1:       return (c == 0) ? 32'(ch0)   : 32'(ch1);
            2:       return (c == 0) ? 32'(dv0)   : 32'(dv1);
            3:       return (c == 0) ? 32'(se0)   : 32'(se1);
            default: return (c == 0) ? 32'(lk0)   : 32'(lk1);
        endcase
    endfunction

    function automatic logic [31:0] get_exp(input int c, input int f);
        case (f)
            0:       return m_data[c];
            1:       return 32'(m_ch[c]);
            2:       return 32'(m_valid[c]);
            3:       return 32'(m_short[c]);
            default: return (m_mode[c] == 2) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = 0; m_pws[c] = 1'b0; m_data[c] = '0; m_ch[c] = 1'b0;
            m_valid[c] = 1'b0; m_short[c] = 1'b0; m_n[c] = 0;
        end
    endfunction

    function automatic void push(input int c, input bit b);
        if (m_n[c] < 32) m_bits[c][m_n[c]] = b;
        m_n[c]++;
    endfunction

    // Config 0 packs MSB-first left-aligned, config 1 places bit k at position k.
    function automatic logic [31:0] pack(input int c);
        logic [31:0] v = '0;
        int n = (m_n[c] < W) ? m_n[c] : W;
        for (int i = 0; i < n; i++) begin
            if (c == 0) v |= 32'(m_bits[c][i]) << (W - 1 - i);
            else        v |= 32'(m_bits[c][i]) << i;
        end
        return v;
    endfunction

    function automatic void model_step(input bit e, input bit w, input bit b);
        for (int c = 0; c < 2; c++) begin
            bit dly = (c == 0);
            bit edg = (m_mode[c] != 0) && (w != m_pws[c]);
            m_valid[c] = 1'b0;
            m_short[c] = 1'b0;
            if (m_mode[c] == 2 && edg) begin
                if (dly) push(c, b);
                m_data[c]  = pack(c);
                m_ch[c]    = m_pws[c];
                m_valid[c] = 1'b1;
                m_short[c] = (m_n[c] < W);
                m_n[c]     = 0;
                if (!dly) push(c, b);
            end else if (m_mode[c] == 1 && edg && e) begin
                m_n[c] = 0;
                if (!dly) push(c, b);
            end else if (m_mode[c] == 2 && e) begin
                push(c, b);
            end
            case (m_mode[c])
                0:       m_mode[c] = e ? 1 : 0;
                1:       m_mode[c] = !e ? 0 : (edg ? 2 : 1);
                default: m_mode[c] = !e ? 0 : 2;
            endcase
            m_pws[c] = w;
        end
    endfunction

    task automatic check_all();
        for (int c = 0; c < 2; c++)
            for (int f = 0; f < 5; f++)
                chk($sformatf("u%0d.%s", c, fname[f]), get_out(c, f), get_exp(c, f));
    endtask

    task automatic tick(input bit e, input bit w, input bit b);
        en = e; ws = w; d_in = b;
        @(posedge bclk);
        #1;
        model_step(e, w, b);
        check_all();
    endtask

    task automatic capture();
        first_v0 = dv0; first_d0 = 32'(data0); first_s0 = se0; first_c0 = ch0;
        first_v1 = dv1; first_d1 = 32'(data1); first_s1 = se1; first_c1 = ch1;
    endtask

    // I2S framing: each bit lags ws by one cycle; the last bit rides the next edge.
    task automatic send_i2s(input bit c, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, c, pend);
            if (i == 0) capture();
            pend = v[n-1-i];
        end
    endtask

    task automatic send_lj(input bit c, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, c, v[i]);
            if (i == 0) capture();
        end
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge bclk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit          chn;
        int          nbits;
        logic [31:0] val;
        logic [31:0] exp;
        bit          exp_short;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt_sv;
        bit  cur;
        tbl[0] = '{1'b0, 18, 32'h2A5A5,   32'h2A5A5, 1'b0};
        tbl[1] = '{1'b1, 18, 32'h1F00F,   32'h1F00F, 1'b0};
        tbl[2] = '{1'b0, 16, 32'hBEEF,    32'h2FBBC, 1'b1};
        tbl[3] = '{1'b1, 24, 32'hABCDEF,  32'h2AF37, 1'b0};
        tbl[4] = '{1'b0, 18, 32'h3FFFF,   32'h3FFFF, 1'b0};
        tbl[5] = '{1'b1, 1,  32'h1,       32'h20000, 1'b1};
        tbl[6] = '{1'b0, 18, 32'h00001,   32'h00001, 1'b0};

        reset = 1'b0; en = 1'b0; ws = 1'b0; d_in = 1'b0;
        #12;
        model_reset();
        check_all();
        @(negedge bclk);
        reset = 1'b1;

        // Table-driven frames on the I2S instance.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            send_i2s(tbl[k].chn, tbl[k].nbits, tbl[k].val);
            if (k > 0) begin
                chk($sformatf("tbl%0d.valid", k-1), 32'(first_v0), 32'd1);
                chk($sformatf("tbl%0d.data",  k-1), first_d0, tbl[k-1].exp);
                chk($sformatf("tbl%0d.short", k-1), 32'(first_s0), 32'(tbl[k-1].exp_short));
                chk($sformatf("tbl%0d.ch",    k-1), 32'(first_c0), 32'(tbl[k-1].chn));
            end
        end
        send_i2s(1'b1, 18, 32'h12345);
        chk("tbl6.valid", 32'(first_v0), 32'd1);
        chk("tbl6.data",  first_d0, tbl[6].exp);
        chk("tbl6.short", 32'(first_s0), 32'(tbl[6].exp_short));

        // Left-justified LSB-first word on the second instance.
        send_lj(1'b0, 18, 32'h00003);
        send_lj(1'b1, 18, 32'h2468A);
        chk("lj.valid", 32'(first_v1), 32'd1);
        chk("lj.data",  first_d1, 32'h00003);
        chk("lj.short", 32'(first_s1), 32'd0);
        chk("lj.ch",    32'(first_c1), 32'd0);
        send_lj(1'b0, 18, 32'h0);
        chk("lj2.data", first_d1, 32'h2468A);
        chk("lj2.ch",   32'(first_c1), 32'd1);

        // Edge at an arbitrary point after reset: locked rises, no strobe for the partial word.
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        chk("lock.before_edge", 32'(lk0), 32'd0);
        tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        chk("lock.at_edge",  32'(lk0), 32'd1);
        chk("lock.no_strobe", 32'(dv0), 32'd0);

        // Reset in the middle of a word.
        send_i2s(1'b0, 18, 32'h15555);
        send_i2s(1'b1, 9, 32'h1FF);
        chk("data_before_reset", first_d0, 32'h15555);
        do_reset();
        chk("rst.data", 32'(data0), 32'd0);
        cnt_sv = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            if (dv0) cnt_sv++;
        end
        chk("rst.no_strobe", 32'(cnt_sv), 32'd0);

        // Drop en mid-word, then recover.
        send_i2s(1'b0, 18, 32'h0F0F0);
        send_i2s(1'b1, 9, 32'h155);
        chk("en.prev_word", first_d0, 32'h0F0F0);
        cnt_sv = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            if (dv0) cnt_sv++;
            chk("en.hold_data", 32'(data0), 32'h0F0F0);
        end
        chk("en.no_strobe", 32'(cnt_sv), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        send_i2s(1'b0, 18, 32'h3C3C3);
        send_i2s(1'b1, 18, 32'h00FF0);
        chk("en.recover_data", first_d0, 32'h3C3C3);
        chk("en.recover_short", 32'(first_s0), 32'd0);
        send_i2s(1'b0, 18, 32'h0);
        chk("en.recover_data2", first_d0, 32'h00FF0);
        chk("en.recover_ch2", 32'(first_c0), 32'd1);

        // Random framing with occasional enable drops, checked against the model.
        cur = ws;
        for (int k = 0; k < 150; k++) begin
            int len = int'($urandom_range(1, 30));
            cur = ~cur;
            for (int j = 0; j < len; j++)
                tick(1'($urandom_range(0, 39) != 0), cur, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
